// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display driver.
// Glyph table is active-low, seg[0]=a .. seg[6]=g.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational hex nibble to active-low 7-segment glyph.
// One instance serves every digit through the scan mux.
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH[nib_i];

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed hex display with frame-aligned value commit,
// leading-zero blanking, decimal points and whole-display blink.
module hex_scan_display
  import hex_display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = idx_w(DIGITS);
  localparam int CW = idx_w(DIV);
  localparam int FW = idx_w(BLINK_FRAMES);

  localparam logic [IW-1:0] LAST  = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CLAST = CW'(DIV - 1);
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shown_q, shown_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d;
  logic                  pv_q, pv_d;
  logic [FW-1:0]         fcnt_q, fcnt_d;
  logic                  ph_q, ph_d;
  logic                  fon_q, fon_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fd_q, fd_d;

  logic                  tick, wrap, accept;
  logic                  lit_on, zero, blk;
  logic [3:0]            nib;
  logic [6:0]            glyph;

  hex_seg_lut u_lut (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    tick    = (cnt_q == CLAST);
    wrap    = tick && (idx_q == LAST);
    accept  = load_valid && !pv_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shown_d = shown_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    fcnt_d  = fcnt_q;
    ph_d    = ph_q;
    fon_d   = fon_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = an_q;
    fd_d    = wrap;
    nib     = shown_d[3:0];
    zero    = 1'b1;
    blk     = 1'b0;

    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end

    // A wrap-cycle load with nothing pending goes straight to shown.
    if (wrap && pv_q) begin
      shown_d = pend_q;
      pv_d    = 1'b0;
    end else if (accept) begin
      if (wrap) begin
        shown_d = value;
      end else begin
        pend_d = value;
        pv_d   = 1'b1;
      end
    end

    // fon holds the blink phase latched for the frame now showing.
    if (wrap) begin
      fon_d = ph_q;
      if (fcnt_q == FLAST) begin
        fcnt_d = '0;
        ph_d   = !ph_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
    lit_on = wrap ? ph_q : fon_q;

    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_d) nib = shown_d[4*i +: 4];
    end

    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero = zero && (shown_d[4*i +: 4] == 4'h0);
      if (blank_lz && zero && (IW'(i) == idx_d)) blk = 1'b1;
    end

    if (tick) begin
      if (blk) begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
      end else begin
        seg_d = glyph;
        dp_d  = !dp_mask[idx_d];
        an_d  = (blink && !lit_on) ? '1
              : ~(DIGITS'(1) << idx_d);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= LAST;
      shown_q <= '0;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      fcnt_q  <= '0;
      ph_q    <= 1'b1;
      fon_q   <= 1'b1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      fcnt_q  <= fcnt_d;
      ph_q    <= ph_d;
      fon_q   <= fon_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign load_ready = !pv_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: directed scenarios plus random traffic
// checked every cycle against a tick/frame arithmetic model.
module tb_hex_scan_display;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BF     = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hex_scan_display #(
    .DIGITS       (DIGITS),
    .DIV          (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .blink      (blink),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  int          t;
  logic [15:0] m_shown, m_pend;
  bit          m_pv;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [3:0]  m_an;
  logic        m_fd;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0d",
             tag, obs, exp, t);
    end
  endtask

  task automatic m_reset();
    m_shown = '0;
    m_pend  = '0;
    m_pv    = 1'b0;
    m_seg   = 7'h7F;
    m_dp    = 1'b1;
    m_an    = 4'hF;
    m_fd    = 1'b0;
    t       = 0;
  endtask

  task automatic check_outs();
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("dp", 32'(dp), 32'(m_dp));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("load_ready", 32'(load_ready), 32'(!m_pv));
  endtask

  // Model one clock: tick n shows digit n%DIGITS of frame n/DIGITS.
  task automatic step();
    int n, d, frame;
    bit tick, wrap, acc, blk, on;
    tick = (t % DIV) == DIV - 1;
    n    = t / DIV;
    d    = n % DIGITS;
    wrap = tick && (d == 0);
    acc  = load_valid && !m_pv;
    if (wrap && m_pv) begin
      m_shown = m_pend;
      m_pv    = 1'b0;
    end else if (acc) begin
      if (wrap) m_shown = value;
      else begin
        m_pend = value;
        m_pv   = 1'b1;
      end
    end
    m_fd = wrap;
    if (tick) begin
      frame = n / DIGITS;
      on    = ((frame / BF) % 2) == 0;
      blk   = blank_lz && d > 0 && ((m_shown >> (4 * d)) == 0);
      if (blk) begin
        m_seg = 7'h7F;
        m_dp  = 1'b1;
        m_an  = 4'hF;
      end else begin
        m_seg = glyph(4'((m_shown >> (4 * d)) & 16'hF));
        m_dp  = !dp_mask[d];
        m_an  = (blink && !on) ? 4'hF : 4'(~(4'b0001 << d));
      end
    end
    @(posedge clock);
    #1;
    t++;
    check_outs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input logic [15:0] v);
    bit ok, r;
    ok = 1'b0;
    value = v;
    load_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      r = load_ready;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    chk("load_accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    m_reset();
    check_outs();
    reset = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic align(input int phase);
    for (int k = 0; k < 32; k++) begin
      if ((t % (DIV * DIGITS)) == phase) break;
      step();
    end
    chk("align", 32'(t % (DIV * DIGITS)), 32'(phase));
  endtask

  initial begin
    m_reset();
    // Load offered during reset must be ignored.
    value = 16'hFFFF;
    load_valid = 1'b1;
    do_reset();
    run(4);
    chk("first_an", 32'(an), 32'h E);
    chk("first_seg", 32'(seg), 32'h40);
    chk("first_fd", 32'(frame_done), 32'd1);

    run(5);
    load(16'h12AF);
    chk("pend_ready", 32'(load_ready), 32'd0);
    run(40);

    blank_lz = 1'b1;
    load(16'h0030);
    run(36);
    load(16'h0000);
    run(36);
    blank_lz = 1'b0;

    align(6);
    load(16'hA1A2);
    load(16'hB3B4);
    run(40);

    align(3);
    value = 16'h5C7E;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("bypass_an", 32'(an), 32'hE);
    chk("bypass_seg", 32'(seg), 32'h06);
    chk("bypass_ready", 32'(load_ready), 32'd1);
    run(20);

    blink = 1'b1;
    dp_mask = 4'b0010;
    run(16 * 8);
    blink = 1'b0;
    dp_mask = 4'b0000;

    for (int k = 0; k < 600; k++) begin
      if (!(load_valid && !load_ready)) begin
        load_valid = ($urandom % 4) == 0;
        value = 16'($urandom);
        if (($urandom % 3) == 0) value[15:8] = 8'h00;
      end
      if ((k % 37) == 0) begin
        dp_mask  = 4'($urandom);
        blank_lz = 1'($urandom);
        blink    = 1'($urandom);
      end
      step();
    end
    load_valid = 1'b0;
    blink = 1'b0;
    blank_lz = 1'b0;
    run(40);

    align(8);
    load(16'hABCD);
    chk("mid_pend", 32'(load_ready), 32'd0);
    value = 16'h1234;
    load_valid = 1'b1;
    do_reset();
    run(4);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
